// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the multi-group 7-segment display controller (package seg_pkg):
// segment encodings, register layout, scan slots and dark output values.
package seg_pkg;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;

  localparam int unsigned DIG_WORD_BASE = 0;
  localparam int unsigned DIG_HEX_LSB   = 0;
  localparam int unsigned DIG_DP_LSB    = 16;
  localparam int unsigned DIG_BLANK_LSB = 20;
  localparam int unsigned DIG_BLINK_LSB = 24;
  localparam int unsigned CTRL_EN_BIT   = 0;

  localparam logic [7:0] SEG_DARK = 8'hFF;
  localparam logic [3:0] SEL_DARK = 4'hF;

  // Active-low g..a patterns, entry 15 (F) listed first.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [3:0] sel_onehot_n(input slot_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Peripheral bus bundle for seg_display_ctrl: byte-enabled writes, combinational read data.
interface seg_display_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic [3:0]        dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [31:0]       dev_wdata;
  logic [31:0]       dev_rdata;

  modport master (output dev_we, output dev_addr, output dev_wdata, input  dev_rdata);
  modport slave  (input  dev_we, input  dev_addr, input  dev_wdata, output dev_rdata);
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex to active-low 7-segment (g..a) decoder; all 16 codes are valid.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  assign seg_n = HEX7_TABLE[hex];
endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped GROUPS x 4-digit multiplexed 7-segment controller.
// Optional blinking is compiled in when macro SEG_BLINK_EN is defined.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int GROUPS    = 3,
  parameter int ADDR_W    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk_in,
  input  logic                  sys_rstn,
  seg_display_ctrl_if.slave     bus,
  output logic [8*GROUPS-1:0]   seg,
  output logic [4*GROUPS-1:0]   sel
);

`ifdef SEG_BLINK_EN
  localparam int DIG_W = 28;
`else
  localparam int DIG_W = 24;
`endif
  localparam int WI_W = ADDR_W - 2;
  localparam int PW   = $clog2(SCAN_DIV);

  if (GROUPS < 1 || GROUPS > 7) begin : g_chk_groups
    $error("GROUPS must be 1..7");
  end
  if ((1 << WI_W) < GROUPS + 1) begin : g_chk_addr
    $error("ADDR_W too small for register map");
  end
  if (SCAN_DIV < 2) begin : g_chk_scan
    $error("SCAN_DIV must be >= 2");
  end
  if (BLINK_DIV < 1) begin : g_chk_blink
    $error("BLINK_DIV must be >= 1");
  end

  logic [DIG_W-1:0] dig_q  [GROUPS];
  logic [DIG_W-1:0] wr_dig [GROUPS];
  logic [GROUPS-1:0] dig_hit;
  logic              ctrl_hit;
  logic              en_q;
  logic [WI_W-1:0]   widx;
  logic [1:0]        unused_addr_lsb;

  assign widx            = bus.dev_addr[ADDR_W-1:2];
  assign unused_addr_lsb = bus.dev_addr[1:0];
  assign ctrl_hit        = (widx == WI_W'(GROUPS));

  always_comb begin
    for (int unsigned g = 0; g < GROUPS; g++) begin
      dig_hit[g] = (widx == WI_W'(DIG_WORD_BASE + g));
      wr_dig[g]  = DIG_W'(byte_merge(32'(dig_q[g]), bus.dev_wdata, bus.dev_we));
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int unsigned g = 0; g < GROUPS; g++) dig_q[g] <= '0;
      en_q <= 1'b0;
    end else if (|bus.dev_we) begin
      for (int unsigned g = 0; g < GROUPS; g++) begin
        if (dig_hit[g]) dig_q[g] <= wr_dig[g];
      end
      if (ctrl_hit && bus.dev_we[CTRL_EN_BIT / 8]) en_q <= bus.dev_wdata[CTRL_EN_BIT];
    end
  end

  always_comb begin
    bus.dev_rdata = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (dig_hit[g]) bus.dev_rdata = 32'(dig_q[g]);
    end
    if (ctrl_hit) bus.dev_rdata[CTRL_EN_BIT] = en_q;
  end

  // Scan prescaler and digit-slot sequencer
  logic [PW-1:0] pre_q;
  logic          tick;
  slot_e         slot_q, slot_d;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) pre_q <= '0;
    else           pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) slot_q <= SLOT0;
    else           slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      unique case (slot_q)
        SLOT0: slot_d = SLOT1;
        SLOT1: slot_d = SLOT2;
        SLOT2: slot_d = SLOT3;
        SLOT3: slot_d = SLOT0;
        default: slot_d = SLOT0;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (tick && slot_q == SLOT3) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end
`endif

  // Each group latches the current slot at terminal count; disable overrides every cycle.
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [3:0] hex;
    logic [6:0] hex_seg;
    logic [3:0] dp_m;
    logic [3:0] blank_m;
    logic       slot_dark;
    logic [7:0] seg_q;
    logic [3:0] sel_q;

    always_comb begin
      hex       = dig_q[g][DIG_HEX_LSB + 4*int'(slot_q) +: 4];
      dp_m      = dig_q[g][DIG_DP_LSB +: 4];
      blank_m   = dig_q[g][DIG_BLANK_LSB +: 4];
      slot_dark = blank_m[slot_q];
`ifdef SEG_BLINK_EN
      slot_dark = slot_dark | (blink_ph_q & dig_q[g][DIG_BLINK_LSB + int'(slot_q)]);
`endif
    end

    seg_hex_decoder u_dec (
      .hex   (hex),
      .seg_n (hex_seg)
    );

    always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
        seg_q <= SEG_DARK;
        sel_q <= SEL_DARK;
      end else if (!en_q) begin
        seg_q <= SEG_DARK;
        sel_q <= SEL_DARK;
      end else if (tick) begin
        if (slot_dark) begin
          seg_q <= SEG_DARK;
          sel_q <= SEL_DARK;
        end else begin
          seg_q <= {~dp_m[slot_q], hex_seg};
          sel_q <= sel_onehot_n(slot_q);
        end
      end
    end

    assign seg[8*g +: 8] = seg_q;
    assign sel[4*g +: 4] = sel_q;
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl (GROUPS=3, SCAN_DIV=4, BLINK_DIV=2).
module tb_seg_display_ctrl;

  localparam int GROUPS    = 3;
  localparam int ADDR_W    = 5;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [8*GROUPS-1:0] seg;
  logic [4*GROUPS-1:0] sel;

  seg_display_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  seg_display_ctrl #(
    .GROUPS    (GROUPS),
    .ADDR_W    (ADDR_W),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk_in   (clk),
    .sys_rstn (rst_n),
    .bus      (bus),
    .seg      (seg),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

`ifdef SEG_BLINK_EN
  localparam logic [31:0] TOP_BYTE_EXP = 32'h0FAB_1234;
`else
  localparam logic [31:0] TOP_BYTE_EXP = 32'h00AB_1234;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_grp(input string name, input int g, input logic [3:0] esel, input logic [7:0] eseg);
    check({name, "_sel"}, 32'(sel[4*g +: 4]), 32'(esel));
    check({name, "_seg"}, 32'(seg[8*g +: 8]), 32'(eseg));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] we);
    bus.dev_addr  = addr;
    bus.dev_wdata = data;
    bus.dev_we    = we;
    step();
    bus.dev_we    = 4'h0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus.dev_addr = addr;
    #1;
    check(name, bus.dev_rdata, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dev_we = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'hF, 5'd0,  32'h0000_1234, 32'h0000_1234};
    vecs[1]  = '{4'h4, 5'd0,  32'h00AB_0000, 32'h00AB_1234};
    vecs[2]  = '{4'h8, 5'd0,  32'hFFFF_FFFF, TOP_BYTE_EXP};
    vecs[3]  = '{4'h2, 5'd4,  32'h0000_5600, 32'h0000_5600};
    vecs[4]  = '{4'h1, 5'd4,  32'h1234_5678, 32'h0000_5678};
    vecs[5]  = '{4'hF, 5'd12, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[6]  = '{4'hF, 5'd12, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{4'hF, 5'd20, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[8]  = '{4'h0, 5'd0,  32'h0000_0000, TOP_BYTE_EXP};
    vecs[9]  = '{4'h0, 5'd8,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{4'hF, 5'd8,  32'h00F0_0000, 32'h00F0_0000};
    vecs[11] = '{4'h2, 5'd9,  32'h0000_7700, 32'h00F0_7700};
    vecs[12] = '{4'hF, 5'd28, 32'h0000_00FF, 32'h0000_0000};

    bus.dev_we = 4'h0; bus.dev_addr = '0; bus.dev_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'hFF_FFFF);
    check("rst_sel", 32'(sel), 32'h0000_0FFF);
    for (int w = 0; w < 4; w++) rd_chk($sformatf("rst_reg%0d", w), 5'(4*w), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Register map and byte merge
    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    step();
    check("disabled_dark", 32'(seg), 32'hFF_FFFF);

    // Scan timing, simultaneous write, blank mask, disable
    do_reset();
    wr(5'd4,  32'h0001_000F, 4'hF);
    wr(5'd12, 32'h0000_0001, 4'hF);
    go_to(3);  check("pre_tick_dark", 32'(sel), 32'h0000_0FFF);
    go_to(4);  chk_grp("s0_g1", 1, 4'hE, 8'h0E); chk_grp("s0_g0", 0, 4'hE, 8'hC0);
    go_to(7);  chk_grp("s0_hold", 1, 4'hE, 8'h0E);
    go_to(8);  chk_grp("s1_g1", 1, 4'hD, 8'hC0);
    go_to(12); chk_grp("s2_g1", 1, 4'hB, 8'hC0);
    go_to(16); chk_grp("s3_g1", 1, 4'h7, 8'hC0);
    go_to(20); chk_grp("s0_again", 1, 4'hE, 8'h0E);
    go_to(23); wr(5'd4, 32'h0000_0550, 4'hF);
    chk_grp("tick_wr_old", 1, 4'hD, 8'hC0);
    go_to(28); chk_grp("tick_wr_new", 1, 4'hB, 8'h92);
    wr(5'd4, 32'h0040_0550, 4'hF);
    go_to(40); chk_grp("pre_blank", 1, 4'hD, 8'h92);
    go_to(44); chk_grp("blank_s2", 1, 4'hF, 8'hFF); chk_grp("blank_other", 0, 4'hB, 8'hC0);
    wr(5'd12, 32'h0, 4'h1);
    step();
    check("ctrl_off_seg", 32'(seg), 32'hFF_FFFF);
    check("ctrl_off_sel", 32'(sel), 32'h0000_0FFF);

    // Async reset mid-scan at slot 2
    wr(5'd12, 32'h0000_0001, 4'hF);
    go_to(60); chk_grp("pre_rst_s2", 0, 4'hB, 8'hC0);
    rst_n = 1'b0;
    #1;
    check("midrst_seg", 32'(seg), 32'hFF_FFFF);
    check("midrst_sel", 32'(sel), 32'h0000_0FFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    wr(5'd12, 32'h0000_0001, 4'hF);
    go_to(3); check("post_rst_dark", 32'(sel), 32'h0000_0FFF);
    go_to(4); chk_grp("post_rst_s0", 0, 4'hE, 8'hC0);

`ifdef SEG_BLINK_EN
    // Blink on digit 0 of group 0
    do_reset();
    wr(5'd0,  32'h0100_0000, 4'hF);
    wr(5'd12, 32'h0000_0001, 4'hF);
    go_to(4);  chk_grp("blink_r0", 0, 4'hE, 8'hC0);
    go_to(20); chk_grp("blink_r1", 0, 4'hE, 8'hC0);
    go_to(36); chk_grp("blink_r2", 0, 4'hF, 8'hFF);
    go_to(40); chk_grp("blink_d1", 0, 4'hD, 8'hC0);
    go_to(52); chk_grp("blink_r3", 0, 4'hF, 8'hFF);
    go_to(68); chk_grp("blink_r4", 0, 4'hE, 8'hC0);
`else
    wr(5'd0, 32'h0F00_0000, 4'h8);
    rd_chk("no_blink_bits", 5'd0, 32'h0000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
